// File: rtl/proc_pkg.sv
// Shared processor-wide constants and types: register index width, default
// writeback queue geometry, and a helper that maps an index to a one-hot register mask.
package proc_pkg;

    localparam int WB_DEPTH    = 4;
    localparam int WB_DATAW    = 32;
    localparam int REG_INDEX_W = 5;
    localparam int NUM_REGS    = 1 << REG_INDEX_W;

    typedef logic [REG_INDEX_W-1:0] regIndex_t;
    typedef logic [NUM_REGS-1:0]    regMask_t;

    // r0 is hard-wired, so it never shows up as pending even if asked.
    function automatic regMask_t indexToMask(input regIndex_t idx, input logic valid);
        regMask_t mask;
        mask = '0;
        if (valid && (idx != '0)) begin
            mask[idx] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Producer/consumer bundle of the writeback queue: two result producers in,
// one register-file write port plus status out.
interface writeback_queue_if
    import proc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DATAW = WB_DATAW
) ();

    logic                     memValid;
    regIndex_t                memIndex;
    logic [DATAW-1:0]         memValue;
    logic                     memReady;

    logic                     aluValid;
    regIndex_t                aluIndex;
    logic [DATAW-1:0]         aluValue;
    logic                     aluReady;

    logic                     regWriteW;
    regIndex_t                indexWB;
    logic [DATAW-1:0]         valueInput;
    regMask_t                 pendingMask;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output memValid, memIndex, memValue,
        output aluValid, aluIndex, aluValue,
        input  memReady, aluReady,
        input  regWriteW, indexWB, valueInput, pendingMask, count
    );

    modport slave (
        input  memValid, memIndex, memValue,
        input  aluValid, aluIndex, aluValue,
        output memReady, aluReady,
        output regWriteW, indexWB, valueInput, pendingMask, count
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular result store with two push ports (A lands ahead of B) and one pop port.
// Occupancy, pointers and valid bits reset asynchronously; payload storage does not.
module wb_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DATAW = WB_DATAW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pushA,
    input  regIndex_t                 indexA,
    input  logic [DATAW-1:0]          valueA,
    input  logic                      pushB,
    input  regIndex_t                 indexB,
    input  logic [DATAW-1:0]          valueB,
    input  logic                      pop,
    output regIndex_t                 headIndex,
    output logic [DATAW-1:0]          headValue,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          entryValid,
    output regIndex_t [DEPTH-1:0]     entryIndex
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [PTRW-1:0]  headReg;
    logic [PTRW-1:0]  tailReg;
    logic [CNTW-1:0]  countReg;
    logic [DEPTH-1:0] validReg;
    regIndex_t        indexMem [DEPTH];
    logic [DATAW-1:0] valueMem [DEPTH];

    logic [1:0]       pushCount;
    logic [PTRW-1:0]  slotA;
    logic [PTRW-1:0]  slotB;

    assign pushCount = {1'b0, pushA} + {1'b0, pushB};
    assign slotA     = tailReg;
    // B takes the slot after A when both push, otherwise the tail itself.
    assign slotB     = tailReg + PTRW'(pushA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
            validReg <= '0;
        end else begin
            if (pop) begin
                validReg[headReg] <= 1'b0;
                headReg           <= headReg + 1'b1;
            end
            if (pushA) begin
                validReg[slotA] <= 1'b1;
            end
            if (pushB) begin
                validReg[slotB] <= 1'b1;
            end
            tailReg  <= tailReg + PTRW'(pushCount);
            countReg <= countReg + CNTW'(pushCount) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (pushA) begin
            indexMem[slotA] <= indexA;
            valueMem[slotA] <= valueA;
        end
        if (pushB) begin
            indexMem[slotB] <= indexB;
            valueMem[slotB] <= valueB;
        end
    end

    assign headIndex  = indexMem[headReg];
    assign headValue  = valueMem[headReg];
    assign count      = countReg;
    assign entryValid = validReg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntryIndex
            assign entryIndex[gi] = indexMem[gi];
        end
    endgenerate

endmodule

// File: rtl/writeback_queue.sv
// Merges memory- and ALU-stage results into a single register-file write port,
// one retirement per cycle, and publishes which registers still have writes in flight.
module writeback_queue
    import proc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DATAW = WB_DATAW
) (
    input  logic              clk,
    input  logic              reset,
    writeback_queue_if.slave  bus
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [CNTW-1:0]      occupancy;
    logic                 memReadyInt;
    logic                 aluReadyInt;
    logic                 pushMem;
    logic                 pushAlu;
    logic                 writeEnable;
    regIndex_t            headIndex;
    logic [DATAW-1:0]     headValue;
    logic [DEPTH-1:0]     entryValid;
    regIndex_t [DEPTH-1:0] entryIndex;
    regMask_t             entryMask [DEPTH];
    regMask_t             pendingAcc;

    // Readiness looks only at occupancy; the ALU yields the last free slot to memory.
    assign memReadyInt = (occupancy < CNTW'(DEPTH));
    assign aluReadyInt = (occupancy < CNTW'(DEPTH - 1)) ||
                         ((occupancy == CNTW'(DEPTH - 1)) && !bus.memValid);

    // Results aimed at r0 are consumed but never stored.
    assign pushMem     = bus.memValid && memReadyInt && (bus.memIndex != '0);
    assign pushAlu     = bus.aluValid && aluReadyInt && (bus.aluIndex != '0);
    assign writeEnable = (occupancy != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .DATAW (DATAW)
    ) fifo (
        .clk        (clk),
        .reset      (reset),
        .pushA      (pushMem),
        .indexA     (bus.memIndex),
        .valueA     (bus.memValue),
        .pushB      (pushAlu),
        .indexB     (bus.aluIndex),
        .valueB     (bus.aluValue),
        .pop        (writeEnable),
        .headIndex  (headIndex),
        .headValue  (headValue),
        .count      (occupancy),
        .entryValid (entryValid),
        .entryIndex (entryIndex)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gMask
            assign entryMask[gi] = indexToMask(entryIndex[gi], entryValid[gi]);
        end
    endgenerate

    always_comb begin
        pendingAcc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pendingAcc = pendingAcc | entryMask[i];
        end
        pendingAcc[0] = 1'b0;
    end

    assign bus.memReady    = memReadyInt;
    assign bus.aluReady    = aluReadyInt;
    assign bus.regWriteW   = writeEnable;
    assign bus.indexWB     = writeEnable ? headIndex : '0;
    assign bus.valueInput  = writeEnable ? headValue : '0;
    assign bus.pendingMask = pendingAcc;
    assign bus.count       = occupancy;

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter DATAW, default 32, meaning the result value width.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memValid  input  1  memory-stage result present.
REQ-006 memIndex  input  5  destination register of the memory result.
REQ-007 memValue  input  DATAW  memory result value.
REQ-008 memReady  output  1  memory result accepted this cycle.
REQ-009 aluValid  input  1  ALU-stage result present.
REQ-010 aluIndex  input  5  destination register of the ALU result.
REQ-011 aluValue  input  DATAW  ALU result value.
REQ-012 aluReady  output  1  ALU result accepted this cycle.
REQ-013 regWriteW  output  1  register-file write strobe.
REQ-014 indexWB  output  5  register-file write index.
REQ-015 valueInput  output  DATAW  register-file write data.
REQ-016 pendingMask  output  32  bit n set while any queued entry targets register n.
REQ-017 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-018 A producer transfer SHALL occur on a rising edge where Valid and Ready are both high.
REQ-019 memReady SHALL be high iff count < DEPTH; readiness depends on count only, not on the same-cycle pop.
REQ-020 aluReady SHALL be high iff count < DEPTH-1, or count == DEPTH-1 and memValid is low.
REQ-021 When both producers transfer on the same edge, the memory entry SHALL be enqueued ahead of the ALU entry.
REQ-022 A transferred result with index 0 SHALL be accepted but not enqueued.
REQ-023 regWriteW SHALL equal (count != 0); indexWB and valueInput SHALL be driven combinationally from the head entry.
REQ-024 The head entry SHALL be popped on every edge where regWriteW is high; there is no consumer back-pressure.
REQ-025 When regWriteW is low, indexWB and valueInput SHALL be 0.
REQ-026 Latency SHALL be one cycle: an empty-queue result accepted at edge k is presented during the cycle after edge k and retired at edge k+1.
REQ-027 Push and pop on the same edge SHALL update count by (pushes - 1); head and tail pointers SHALL wrap modulo DEPTH.
REQ-028 pendingMask SHALL be recomputed from valid entries; bit 0 SHALL always be 0.
REQ-029 Entries with the same index SHALL retire in enqueue order, so the last write wins.

Reset
REQ-030 While reset is low: count=0, pointers=0, all entry valid bits=0, regWriteW=0, pendingMask=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries without issuing any further write.
REQ-032 memReady and aluReady SHALL be 1 during and after reset, following REQ-019 and REQ-020 with count=0.

Structure
REQ-033 DEPTH default, DATAW default, and the register-index width (5) SHALL live in shared package proc_pkg.
REQ-034 The storage and pointers SHALL be a sub-module wb_fifo (dual-push, single-pop); arbitration and pendingMask SHALL stay in writeback_queue.

Verification
REQ-035 The bench SHALL cover single push: memValid=1, memIndex=3, memValue=0x11 on an empty queue -> next cycle regWriteW=1, indexWB=3, valueInput=0x11; the cycle after, regWriteW=0.
REQ-036 The bench SHALL cover dual push: mem(5,0xA) and alu(5,0xB) on the same edge -> two writes to r5, 0xA then 0xB, on consecutive cycles; pendingMask[5] is high for exactly two cycles.
REQ-037 The bench SHALL cover full/arbitration: with count=3 and both valid -> memReady=1, aluReady=0; with count=4 -> both ready=0.
REQ-038 The bench SHALL cover the index-0 drop: alu(0,0xFF) accepted -> aluReady=1, count unchanged, no regWriteW.
REQ-039 The bench SHALL cover reset mid-operation: fill to 4, assert reset for 1 cycle -> count=0, regWriteW=0 immediately (asynchronous), and no writes after release.
REQ-040 The bench SHALL cover wrap-around: 10 back-to-back single pushes with indices 1..10 -> 10 writes, one per cycle, in order, with count never exceeding 1.
